// File: rtl/rrarb_pkg.sv
// rrarb_pkg: shared FSM state type and index-width helper for the round-robin arbiter
package rrarb_pkg;
  typedef enum logic {IDLE, OWNED} state_e;
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rrarb_pick.sv
// rrarb_pick: rotate-priority search, first set bit of mask starting after ptr and wrapping to ptr
module rrarb_pick
  import rrarb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = idw(N)
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win,
  output logic [IDW-1:0] win_id
);
  logic found;
  // scan ptr+1 .. ptr+N (mod N); the first requester seen wins
  always_comb begin
    win = '0;
    win_id = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && mask[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        win[(int'(ptr) + i) % N] = 1'b1;
        win_id = IDW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/rrarb_multi.sv
// rrarb_multi: registered round-robin arbiter with hold limit; RRARB_MULTI_PRIO_EN adds request_hi
module rrarb_multi
  import rrarb_pkg::*;
#(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW = idw(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   request,
`ifdef RRARB_MULTI_PRIO_EN
  input  logic [N-1:0]   request_hi,
`endif
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);
  localparam int HCW = idw(MAX_HOLD);
  localparam logic [HCW-1:0] HMAX = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : {HCW{1'b1}};
  state_e state_q, state_d;
  logic [N-1:0] grant_q, grant_d, cand, win;
  logic [IDW-1:0] grant_id_q, grant_id_d, ptr_q, ptr_d, win_id;
  logic [HCW-1:0] hold_q, hold_d;
  logic grant_valid_q, owner_req, hold_hit, preempt, arb;
`ifdef RRARB_MULTI_PRIO_EN
  logic [N-1:0] hi_set;
  assign hi_set = request & request_hi;
  assign cand = |hi_set ? hi_set : request;
  assign preempt = (state_q == OWNED) && |(hi_set & ~grant_q) && !(|(request_hi & grant_q));
`else
  assign cand = request;
  assign preempt = 1'b0;
`endif
  rrarb_pick #(.N(N)) u_pick (
    .mask(cand),
    .ptr(ptr_q),
    .win(win),
    .win_id(win_id)
  );
  // decide whether this edge re-arbitrates, and derive next owner, pointer and hold count
  always_comb begin
    owner_req = |(request & grant_q);
    hold_hit = (MAX_HOLD > 0) && (hold_q == HMAX) && |(request & ~grant_q);
    arb = (state_q == IDLE) || !owner_req || hold_hit || preempt;
    grant_d = arb ? win : grant_q;
    grant_id_d = arb ? win_id : grant_id_q;
    ptr_d = |grant_d ? grant_id_d : ptr_q;
    state_d = |grant_d ? OWNED : IDLE;
    hold_d = (grant_d != grant_q || !(|grant_d)) ? '0 : (hold_q == HMAX ? hold_q : hold_q + 1'b1);
  end
  // state and registered outputs; reset leaves ptr at N-1 so index 0 is searched first
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q <= '0;
      hold_q <= '0;
      ptr_q <= IDW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      grant_valid_q <= |grant_d;
      grant_id_q <= grant_id_d;
      hold_q <= hold_d;
      ptr_q <= ptr_d;
    end
  end
  assign grant = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id = grant_id_q;
endmodule

// File: tb/tb_rrarb_multi.sv
// tb_rrarb_multi: directed checks of rrarb_multi with MAX_HOLD=8 and MAX_HOLD=0 instances
module tb_rrarb_multi;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] request;
  logic [3:0] g, g0;
  logic gv, gv0;
  logic [1:0] gid, gid0;
  int checks = 0;
  int errors = 0;
`ifdef RRARB_MULTI_PRIO_EN
  logic [3:0] request_hi;
`endif
  always #5 clk = ~clk;
  rrarb_multi #(.N(4), .MAX_HOLD(8)) dut (
    .clk(clk),
    .reset(reset),
    .request(request),
`ifdef RRARB_MULTI_PRIO_EN
    .request_hi(request_hi),
`endif
    .grant(g),
    .grant_valid(gv),
    .grant_id(gid)
  );
  rrarb_multi #(.N(4), .MAX_HOLD(0)) dut0 (
    .clk(clk),
    .reset(reset),
    .request(request),
`ifdef RRARB_MULTI_PRIO_EN
    .request_hi(request_hi),
`endif
    .grant(g0),
    .grant_valid(gv0),
    .grant_id(gid0)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end
  initial begin
    logic [31:0] e;
    reset = 1'b1;
    request = 4'b0000;
`ifdef RRARB_MULTI_PRIO_EN
    request_hi = 4'b0000;
`endif
    tick();
    tick();
    reset = 1'b0;
    chk("rst_grant", g, 0);
    chk("rst_valid", gv, 0);
    chk("rst_id", gid, 0);
    request = 4'b1111;
    for (int k = 0; k <= 4; k++) begin
      for (int c = 0; c < ((k == 4) ? 1 : 8); c++) begin
        tick();
        e = 32'(1) << (k % 4);
        chk("rot_grant", g, e);
        chk("rot_id", gid, k % 4);
        chk("nohold_grant", g0, 1);
      end
    end
    request = 4'b0000;
    tick();
    chk("idle_grant", g, 0);
    chk("idle_valid", gv, 0);
    request = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("single_grant", g, 4'b0010);
      chk("single_valid", gv, 1);
      chk("single_id", gid, 1);
    end
    request = 4'b0000;
    tick();
    chk("drop_grant", g, 0);
    chk("drop_valid", gv, 0);
    chk("drop_id", gid, 0);
    request = 4'b0001;
    tick();
    chk("hold_start", g, 4'b0001);
    request = 4'b0101;
    for (int c = 1; c < 8; c++) begin
      tick();
      chk("hold_keep", g, 4'b0001);
      chk("hold0_keep", g0, 4'b0001);
    end
    tick();
    chk("hold_rotate", g, 4'b0100);
    chk("hold_rotate_id", gid, 2);
    chk("hold0_never", g0, 4'b0001);
    request = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("sole_owner", g, 4'b0100);
    end
    chk("sole_owner0", g0, 4'b0100);
    request = 4'b1000;
    tick();
    chk("pre_rst_grant", g, 4'b1000);
    reset = 1'b1;
    request = 4'b1001;
    tick();
    chk("midrst_grant", g, 0);
    chk("midrst_valid", gv, 0);
    chk("midrst_id", gid, 0);
    chk("midrst_grant0", g0, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_grant", g, 4'b0001);
    chk("post_rst_id", gid, 0);
    request = 4'b1000;
    tick();
    chk("no_dead_grant", g, 4'b1000);
    chk("no_dead_id", gid, 3);
    request = 4'b1010;
    tick();
    tick();
    request = 4'b1000;
    tick();
    chk("midgrant_ignore", g, 4'b1000);
    request = 4'b0000;
    tick();
    chk("end_idle", g, 0);
    chk("end_idle_valid", gv, 0);
`ifdef RRARB_MULTI_PRIO_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    request = 4'b0010;
    tick();
    chk("prio_owner1", g, 4'b0010);
    request = 4'b1110;
    request_hi = 4'b1000;
    tick();
    chk("prio_preempt", g, 4'b1000);
    chk("prio_preempt_id", gid, 3);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("prio_hi_keeps", g, 4'b1000);
    end
    request = 4'b0110;
    request_hi = 4'b0000;
    tick();
    chk("prio_after_hi", g, 4'b0010);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
